// File: rtl/mining_pkg.sv
// mining_pkg: shared widths and the hash word-index encoding for the mining datapath
package mining_pkg;
  localparam int HASH_W = 256;
  localparam int WORD_W = 64;
  localparam int WORDS_PER_HASH = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, W1 = 2'd1, W2 = 2'd2, W3 = 2'd3} word_idx_e;
endpackage

// File: rtl/hash_word_serializer.sv
// hash_word_serializer: buffers 256-bit hashes and streams them as 64-bit words, MSW first
module hash_word_serializer
  import mining_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HASH_W-1:0] hash_in,
  input  logic              hash_in_valid,
  output logic              hash_in_ready,
  input  logic              rd_en,
  output logic [WORD_W-1:0] dout,
  output logic              dout_we,
  input  logic              flush,
  output logic              empty,
  output logic [4:0]        level,
  output logic [15:0]       drop_cnt
);
  localparam int PW = $clog2(DEPTH);
  logic [HASH_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [4:0]        r_level;
  logic [WORD_W-1:0] r_dout;
  logic              r_dout_we;
  logic [15:0]       r_drop_cnt;
  word_idx_e         r_state, w_state_nx;
  logic              w_accept, w_serve, w_retire;
  logic [WORD_W-1:0] w_word;
  assign hash_in_ready = r_level < 5'(DEPTH);
  assign empty         = r_level == 5'd0;
  assign level         = r_level;
  assign dout          = r_dout;
  assign dout_we       = r_dout_we;
  assign drop_cnt      = r_drop_cnt;
  assign w_accept      = hash_in_valid & hash_in_ready & ~flush;
  assign w_serve       = rd_en & ~empty & ~flush;
  // word-index state register; flush and reset both abandon a partial entry
  always_ff @(posedge clk)
    r_state <= (rst | flush) ? IDLE : w_state_nx;
  // advance one word per served request, wrapping W3 back to IDLE
  always_comb
    w_state_nx = w_serve ? word_idx_e'(r_state + 2'd1) : r_state;
  // pick the current word of the head entry and flag the last-word retirement
  always_comb begin
    w_retire = w_serve && (r_state == word_idx_e'(WORDS_PER_HASH - 1));
    w_word   = r_mem[r_rd_ptr][HASH_W-1-WORD_W*int'(r_state) -: WORD_W];
  end
  // entry storage is never reset; stale contents are unreachable once pointers clear
  always_ff @(posedge clk)
    if (w_accept) r_mem[r_wr_ptr] <= hash_in;
  // pointers and occupancy; accept and retire in one cycle leave level unchanged
  always_ff @(posedge clk)
    if (rst | flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_retire) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + 5'(w_accept) - 5'(w_retire);
    end
  // one-cycle registered word output; dout holds its value when not strobed
  always_ff @(posedge clk)
    if (rst) begin
      r_dout    <= '0;
      r_dout_we <= 1'b0;
    end else begin
      r_dout_we <= w_serve;
      if (w_serve) r_dout <= w_word;
    end
  // saturating count of hashes offered while full; survives flush
  always_ff @(posedge clk)
    if (rst) r_drop_cnt <= '0;
    else if (hash_in_valid && !hash_in_ready && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
endmodule

// File: tb/tb_hash_word_serializer.sv
// tb_hash_word_serializer: scoreboard bench with a queue model of the hash buffer
module tb_hash_word_serializer;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] hash_in = '0;
  logic         hash_in_valid = 1'b0;
  logic         hash_in_ready;
  logic         rd_en = 1'b0;
  logic [63:0]  dout;
  logic         dout_we;
  logic         flush = 1'b0;
  logic         empty;
  logic [4:0]   level;
  logic [15:0]  drop_cnt;
  int n_vec = 0;
  int n_err = 0;
  logic [255:0] m_q[$];
  logic [63:0]  sb[$];
  int           m_idx = 0;
  int           m_drop = 0;
  logic [63:0]  m_dout = '0;
  int           n_words = 0;
  hash_word_serializer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .hash_in(hash_in), .hash_in_valid(hash_in_valid),
    .hash_in_ready(hash_in_ready), .rd_en(rd_en), .dout(dout), .dout_we(dout_we),
    .flush(flush), .empty(empty), .level(level), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_status();
    chk("level", 256'(level), 256'(m_q.size()));
    chk("ready", 256'(hash_in_ready), 256'(m_q.size() < 4));
    chk("empty", 256'(empty), 256'(m_q.size() == 0));
    chk("drop_cnt", 256'(drop_cnt), 256'(m_drop));
  endtask
  task automatic cyc(input logic v, input logic [255:0] h, input logic r, input logic f);
    logic [255:0] tmp;
    logic m_ready, served, retire;
    logic [63:0] w;
    hash_in_valid = v; hash_in = h; rd_en = r; flush = f;
    m_ready = m_q.size() < 4;
    served = r && !f && m_q.size() > 0;
    retire = served && m_idx == 3;
    if (served) begin
      tmp = m_q[0];
      w = tmp[255-64*m_idx -: 64];
      sb.push_back(w);
    end
    if (v && !m_ready && m_drop < 16'hFFFF) m_drop++;
    if (f) begin
      m_q.delete();
      m_idx = 0;
    end else begin
      if (served) m_idx = (m_idx + 1) % 4;
      if (retire) void'(m_q.pop_front());
      if (v && m_ready) m_q.push_back(h);
    end
    @(posedge clk);
    #1;
    hash_in_valid = 1'b0; rd_en = 1'b0; flush = 1'b0;
    chk("dout_we", 256'(dout_we), 256'(served));
    if (dout_we) begin
      n_words++;
      if (sb.size() == 0) chk("sb_underflow", 256'(1), 256'(0));
      else begin
        m_dout = sb.pop_front();
        chk("dout", 256'(dout), 256'(m_dout));
      end
    end else chk("dout_hold", 256'(dout), 256'(m_dout));
    chk_status();
  endtask
  task automatic do_reset();
    rst = 1'b1; hash_in_valid = 1'b0; rd_en = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_q.delete(); sb.delete(); m_idx = 0; m_drop = 0; m_dout = '0;
    chk("rst_dout", 256'(dout), 256'(0));
    chk("rst_dout_we", 256'(dout_we), 256'(0));
    chk_status();
  endtask
  function automatic logic [255:0] rnd_hash();
    logic [255:0] h;
    for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
    return h;
  endfunction
  initial begin
    do_reset();
    cyc(1, 256'h0001_0002_0003_0004_0005_0006_0007_0008_1111_2222_3333_4444_AAAA_BBBB_CCCC_DDDD, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, '0, 1, 0);
    cyc(0, '0, 0, 0);
    cyc(0, '0, 1, 0);
    for (int i = 0; i < 6; i++) cyc(1, rnd_hash(), 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0);
    cyc(1, rnd_hash(), 1, 0);
    cyc(1, rnd_hash(), 0, 0);
    for (int i = 0; i < 40 && m_q.size() > 0; i++) cyc(0, '0, 1, 0);
    cyc(0, '0, 0, 0);
    n_words = 0;
    begin
      int sent = 0;
      for (int c = 0; c < 400 && (sent < 10 || m_q.size() > 0); c++) begin
        logic v;
        v = sent < 10 && m_q.size() < 4;
        if (v) sent++;
        cyc(v, rnd_hash(), (c % 3) == 2, 0);
      end
      cyc(0, '0, 0, 0);
      chk("sparse_words", 256'(n_words), 256'(40));
    end
    for (int i = 0; i < 3; i++) cyc(1, rnd_hash(), 0, 0);
    cyc(0, '0, 1, 0);
    cyc(0, '0, 1, 0);
    cyc(0, '0, 0, 1);
    cyc(0, '0, 1, 0);
    cyc(1, rnd_hash(), 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, '0, 1, 0);
    cyc(1, rnd_hash(), 0, 0);
    cyc(0, '0, 1, 0);
    cyc(0, '0, 1, 0);
    do_reset();
    cyc(1, 256'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF_DEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, '0, 1, 0);
    cyc(0, '0, 0, 0);
    chk("sb_drained", 256'(sb.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
